// File: rtl/data_mem_ctrl_if.sv
// rtl/data_mem_ctrl_if.sv - CPU, debug and data-RAM signal bundle for data_mem_ctrl
interface data_mem_ctrl_if #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 9
);
  logic               i_cpu_req;
  logic               i_cpu_we;
  logic [1:0]         i_cpu_size;
  logic               i_cpu_unsigned;
  logic [NB_ADDR-1:0] i_cpu_addr;
  logic [NB_DATA-1:0] i_cpu_wdata;
  logic [NB_DATA-1:0] o_cpu_rdata;
  logic               o_cpu_ack;
  logic               o_cpu_err;

  logic               i_dbg_req;
  logic               i_dbg_we;
  logic [NB_ADDR-1:0] i_dbg_addr;
  logic [NB_DATA-1:0] i_dbg_wdata;
  logic [NB_DATA-1:0] o_dbg_rdata;
  logic               o_dbg_ack;

  logic               o_mem_we;
  logic [NB_ADDR-1:0] o_mem_addr;
  logic [NB_DATA-1:0] o_mem_wdata;
  logic [NB_DATA-1:0] i_mem_rdata;

  modport slave (
    input  i_cpu_req, i_cpu_we, i_cpu_size, i_cpu_unsigned, i_cpu_addr, i_cpu_wdata,
    output o_cpu_rdata, o_cpu_ack, o_cpu_err,
    input  i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
    output o_dbg_rdata, o_dbg_ack,
    output o_mem_we, o_mem_addr, o_mem_wdata,
    input  i_mem_rdata
  );

  modport master (
    output i_cpu_req, i_cpu_we, i_cpu_size, i_cpu_unsigned, i_cpu_addr, i_cpu_wdata,
    input  o_cpu_rdata, o_cpu_ack, o_cpu_err,
    output i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
    input  o_dbg_rdata, o_dbg_ack,
    input  o_mem_we, o_mem_addr, o_mem_wdata,
    output i_mem_rdata
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - CPU/debug arbiter and RMW sequencer for the big-endian data RAM
// Optional macro DMEM_DBG_PRIORITY_EN gives debug strict priority on ties.
module data_mem_ctrl #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 9
) (
  input  logic           i_clk,
  input  logic           i_reset,
  data_mem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  state_t             state_q, state_d;
  logic               gnt_dbg_q, gnt_dbg_d;
  logic               last_dbg_q, last_dbg_d;
  logic               we_q, we_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [1:0]         off_q, off_d;
  logic [NB_DATA-1:0] wdata_q, wdata_d;
  logic               err_q, err_d;
  logic [NB_ADDR-1:0] mem_addr_q, mem_addr_d;
  logic [NB_DATA-1:0] mem_wdata_q, mem_wdata_d;
  logic [NB_DATA-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [NB_DATA-1:0] dbg_rdata_q, dbg_rdata_d;

  logic               pick_dbg;
  logic               cpu_bad;
  logic [NB_ADDR-1:0] req_addr;
  logic [NB_DATA-1:0] load_val;
  logic [NB_DATA-1:0] merge_val;

`ifdef DMEM_DBG_PRIORITY_EN
  assign pick_dbg = bus.i_dbg_req;
`else
  assign pick_dbg = bus.i_dbg_req && (!bus.i_cpu_req || !last_dbg_q);
`endif

  assign req_addr = pick_dbg ? bus.i_dbg_addr : bus.i_cpu_addr;
  assign cpu_bad  = (bus.i_cpu_size == 2'b11) ||
                    (bus.i_cpu_size == 2'b01 && bus.i_cpu_addr[0]) ||
                    (bus.i_cpu_size == 2'b10 && bus.i_cpu_addr[1:0] != 2'b00);

  // Big-endian lanes: byte offset 0 is the most significant byte of the word.
  always_comb begin
    load_val  = '0;
    merge_val = bus.i_mem_rdata;
    case (size_q)
      2'b00: begin
        case (off_q)
          2'b00: begin load_val[7:0] = bus.i_mem_rdata[31:24]; merge_val[31:24] = wdata_q[7:0]; end
          2'b01: begin load_val[7:0] = bus.i_mem_rdata[23:16]; merge_val[23:16] = wdata_q[7:0]; end
          2'b10: begin load_val[7:0] = bus.i_mem_rdata[15:8];  merge_val[15:8]  = wdata_q[7:0]; end
          default: begin load_val[7:0] = bus.i_mem_rdata[7:0]; merge_val[7:0]   = wdata_q[7:0]; end
        endcase
        if (!uns_q) load_val[31:8] = {24{load_val[7]}};
      end
      2'b01: begin
        if (off_q[1]) begin
          load_val[15:0]  = bus.i_mem_rdata[15:0];
          merge_val[15:0] = wdata_q[15:0];
        end else begin
          load_val[15:0]   = bus.i_mem_rdata[31:16];
          merge_val[31:16] = wdata_q[15:0];
        end
        if (!uns_q) load_val[31:16] = {16{load_val[15]}};
      end
      default: begin
        load_val  = bus.i_mem_rdata;
        merge_val = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    gnt_dbg_d   = gnt_dbg_q;
    last_dbg_d  = last_dbg_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_cpu_req || bus.i_dbg_req) begin
          gnt_dbg_d  = pick_dbg;
          last_dbg_d = pick_dbg;
          off_d      = req_addr[1:0];
          if (pick_dbg) begin
            we_d    = bus.i_dbg_we;
            size_d  = 2'b10;
            uns_d   = 1'b0;
            wdata_d = bus.i_dbg_wdata;
            err_d   = 1'b0;
          end else begin
            we_d    = bus.i_cpu_we;
            size_d  = bus.i_cpu_size;
            uns_d   = bus.i_cpu_unsigned;
            wdata_d = bus.i_cpu_wdata;
            err_d   = cpu_bad;
          end
          if (!pick_dbg && cpu_bad) begin
            state_d     = S_RESP;
            cpu_rdata_d = '0;
          end else begin
            state_d    = S_RD;
            mem_addr_d = {req_addr[NB_ADDR-1:2], 2'b00};
          end
        end
      end
      S_RD: begin
        if (we_q) begin
          mem_wdata_d = merge_val;
          state_d     = S_WR;
        end else begin
          state_d = S_RESP;
          if (gnt_dbg_q) dbg_rdata_d = load_val;
          else           cpu_rdata_d = load_val;
        end
      end
      S_WR: begin
        state_d = S_RESP;
        if (gnt_dbg_q) dbg_rdata_d = '0;
        else           cpu_rdata_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      gnt_dbg_q   <= 1'b0;
      last_dbg_q  <= 1'b0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_dbg_q   <= gnt_dbg_d;
      last_dbg_q  <= last_dbg_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // Write enable is decoded from state so an async reset in WR kills it at once.
  assign bus.o_mem_we    = (state_q == S_WR);
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_wdata = mem_wdata_q;
  assign bus.o_cpu_ack   = (state_q == S_RESP) && !gnt_dbg_q;
  assign bus.o_cpu_err   = (state_q == S_RESP) && !gnt_dbg_q && err_q;
  assign bus.o_dbg_ack   = (state_q == S_RESP) && gnt_dbg_q;
  assign bus.o_cpu_rdata = cpu_rdata_q;
  assign bus.o_dbg_rdata = dbg_rdata_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - scoreboard bench for data_mem_ctrl with a word-wide RAM model
module tb_data_mem_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_ctrl_if #(.NB_DATA(32), .NB_ADDR(9)) bus();
  data_mem_ctrl #(.NB_DATA(32), .NB_ADDR(9)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

  logic [31:0] ram [0:127];
  assign bus.i_mem_rdata = ram[bus.o_mem_addr[8:2]];
  always @(posedge clk) if (bus.o_mem_we) ram[bus.o_mem_addr[8:2]] <= bus.o_mem_wdata;

  typedef struct {logic dbg; logic [31:0] rdata; logic err;} exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int we_cycles = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.o_mem_we) we_cycles++;
    if (bus.o_cpu_ack || bus.o_dbg_ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack cpu_ack=%0b dbg_ack=%0b", bus.o_cpu_ack, bus.o_dbg_ack);
      end else begin
        e = exp_q.pop_front();
        check("ack_owner", {31'd0, bus.o_dbg_ack}, {31'd0, e.dbg});
        if (e.dbg) begin
          check("dbg_rdata", bus.o_dbg_rdata, e.rdata);
        end else begin
          check("cpu_rdata", bus.o_cpu_rdata, e.rdata);
          check("cpu_err", {31'd0, bus.o_cpu_err}, {31'd0, e.err});
        end
      end
    end
  end

  task automatic cpu_op(string nm, logic we, logic [1:0] sz, logic uns, logic [8:0] a,
                        logic [31:0] wd, logic [31:0] exp_rd, logic exp_err, int exp_lat);
    int n;
    n = 0;
    exp_q.push_back('{1'b0, exp_rd, exp_err});
    @(negedge clk);
    bus.i_cpu_req = 1'b1; bus.i_cpu_we = we; bus.i_cpu_size = sz;
    bus.i_cpu_unsigned = uns; bus.i_cpu_addr = a; bus.i_cpu_wdata = wd;
    do begin @(negedge clk); n++; end while (!bus.o_cpu_ack && n < 20);
    bus.i_cpu_req = 1'b0;
    check({nm, "_latency"}, n, exp_lat);
  endtask

  task automatic dbg_op(string nm, logic we, logic [8:0] a, logic [31:0] wd,
                        logic [31:0] exp_rd, int exp_lat);
    int n;
    n = 0;
    exp_q.push_back('{1'b1, exp_rd, 1'b0});
    @(negedge clk);
    bus.i_dbg_req = 1'b1; bus.i_dbg_we = we; bus.i_dbg_addr = a; bus.i_dbg_wdata = wd;
    do begin @(negedge clk); n++; end while (!bus.o_dbg_ack && n < 20);
    bus.i_dbg_req = 1'b0;
    check({nm, "_latency"}, n, exp_lat);
  endtask

  initial begin
    int w0;
    int n;
    for (int i = 0; i < 128; i++) ram[i] = 32'h0;
    bus.i_cpu_req = 0; bus.i_cpu_we = 0; bus.i_cpu_size = 0; bus.i_cpu_unsigned = 0;
    bus.i_cpu_addr = 0; bus.i_cpu_wdata = 0;
    bus.i_dbg_req = 0; bus.i_dbg_we = 0; bus.i_dbg_addr = 0; bus.i_dbg_wdata = 0;
    rst = 1'b1;
    #12;
    check("rst_mem_we", {31'd0, bus.o_mem_we}, 32'd0);
    check("rst_mem_addr", {23'd0, bus.o_mem_addr}, 32'd0);
    check("rst_mem_wdata", bus.o_mem_wdata, 32'd0);
    check("rst_acks", {30'd0, bus.o_cpu_ack, bus.o_dbg_ack}, 32'd0);
    check("rst_err", {31'd0, bus.o_cpu_err}, 32'd0);
    check("rst_rdata", bus.o_cpu_rdata | bus.o_dbg_rdata, 32'd0);
    @(negedge clk); rst = 1'b0;

    w0 = we_cycles;
    dbg_op("dbg_sw", 1'b1, 9'h010, 32'h11223344, 32'h0, 3);
    check("dbg_sw_we_cycles", we_cycles - w0, 32'd1);
    check("dbg_sw_ram", ram[4], 32'h11223344);
    cpu_op("lw", 1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 32'h11223344, 1'b0, 2);
    cpu_op("sb", 1'b1, 2'b00, 1'b0, 9'h012, 32'hFFFFFFAA, 32'h0, 1'b0, 3);
    check("sb_ram", ram[4], 32'h1122AA44);
    cpu_op("lb", 1'b0, 2'b00, 1'b0, 9'h012, 32'h0, 32'hFFFFFFAA, 1'b0, 2);
    cpu_op("lbu", 1'b0, 2'b00, 1'b1, 9'h012, 32'h0, 32'h000000AA, 1'b0, 2);
    cpu_op("lb1", 1'b0, 2'b00, 1'b0, 9'h011, 32'h0, 32'h00000022, 1'b0, 2);
    dbg_op("dbg_sw2", 1'b1, 9'h010, 32'h11223344, 32'h0, 3);
    cpu_op("sh", 1'b1, 2'b01, 1'b0, 9'h010, 32'h00008001, 32'h0, 1'b0, 3);
    check("sh_ram", ram[4], 32'h80013344);
    cpu_op("lh", 1'b0, 2'b01, 1'b0, 9'h010, 32'h0, 32'hFFFF8001, 1'b0, 2);
    cpu_op("lhu", 1'b0, 2'b01, 1'b1, 9'h012, 32'h0, 32'h00003344, 1'b0, 2);
    cpu_op("lb3", 1'b0, 2'b00, 1'b0, 9'h013, 32'h0, 32'h00000044, 1'b0, 2);
    dbg_op("dbg_lw", 1'b0, 9'h013, 32'h0, 32'h80013344, 2);
    cpu_op("sw", 1'b1, 2'b10, 1'b0, 9'h020, 32'hDEADBEEF, 32'h0, 1'b0, 3);
    cpu_op("lh_neg", 1'b0, 2'b01, 1'b0, 9'h022, 32'h0, 32'hFFFFBEEF, 1'b0, 2);
    cpu_op("lw_top", 1'b0, 2'b10, 1'b0, 9'h1FC, 32'h0, 32'h0, 1'b0, 2);

    w0 = we_cycles;
    cpu_op("lw_mis", 1'b0, 2'b10, 1'b0, 9'h013, 32'h0, 32'h0, 1'b1, 1);
    cpu_op("size11", 1'b0, 2'b11, 1'b0, 9'h010, 32'h0, 32'h0, 1'b1, 1);
    cpu_op("sh_mis", 1'b1, 2'b01, 1'b0, 9'h011, 32'h1234, 32'h0, 1'b1, 1);
    check("err_no_we", we_cycles - w0, 32'd0);
    check("err_ram", ram[4], 32'h80013344);

    // Store aborted by reset in its write cycle: no ack is expected.
    n = 0;
    @(negedge clk);
    bus.i_cpu_req = 1'b1; bus.i_cpu_we = 1'b1; bus.i_cpu_size = 2'b00;
    bus.i_cpu_addr = 9'h010; bus.i_cpu_wdata = 32'h55;
    do begin @(negedge clk); n++; end while (!bus.o_mem_we && n < 10);
    check("abort_we_cycle", n, 32'd2);
    #2 rst = 1'b1;
    #1;
    check("abort_we_drop", {31'd0, bus.o_mem_we}, 32'd0);
    check("abort_no_ack", {31'd0, bus.o_cpu_ack}, 32'd0);
    bus.i_cpu_req = 1'b0;
    @(negedge clk); @(negedge clk); rst = 1'b0;
    check("abort_ram", ram[4], 32'h80013344);
    check("abort_addr", {23'd0, bus.o_mem_addr}, 32'd0);

`ifdef DMEM_DBG_PRIORITY_EN
    exp_q.push_back('{1'b1, 32'h80013344, 1'b0});
    exp_q.push_back('{1'b1, 32'h80013344, 1'b0});
    exp_q.push_back('{1'b0, 32'h80013344, 1'b0});
`else
    exp_q.push_back('{1'b1, 32'h80013344, 1'b0});
    exp_q.push_back('{1'b0, 32'h80013344, 1'b0});
    exp_q.push_back('{1'b1, 32'h80013344, 1'b0});
`endif
    @(negedge clk);
    fork
      begin
        int c;
        c = 0;
        bus.i_cpu_req = 1'b1; bus.i_cpu_we = 1'b0; bus.i_cpu_size = 2'b10;
        bus.i_cpu_unsigned = 1'b0; bus.i_cpu_addr = 9'h010;
        do begin @(negedge clk); c++; end while (!bus.o_cpu_ack && c < 40);
        bus.i_cpu_req = 1'b0;
        check("tie_cpu_served", {31'd0, bus.o_cpu_ack}, 32'd1);
      end
      begin
        int c;
        int k;
        c = 0; k = 0;
        bus.i_dbg_req = 1'b1; bus.i_dbg_we = 1'b0; bus.i_dbg_addr = 9'h010;
        while (k < 2 && c < 40) begin
          @(negedge clk); c++;
          if (bus.o_dbg_ack) k++;
        end
        bus.i_dbg_req = 1'b0;
        check("tie_dbg_served", k, 32'd2);
      end
    join
    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
